// File: rtl/xcorr_scheduler.sv
// xcorr_scheduler
//   Computes the sliding cross-correlation c[x] = sum_k f[x+k]*g[k] for
//   x = 0..NLAG-1. It reads f and g from a read-only sample SRAM with a
//   one-cycle read latency, and accumulates the products in a signed MAC.
//   f is stored at addresses 0..F_LEN-1 and g at F_LEN..F_LEN+G_LEN-1.
//   g is read once into a register cache. After that, each lag needs
//   one SRAM read per tap.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   start       one-cycle run request, honoured only when idle
//   busy        high in every non-idle state
//   done        one-cycle pulse when max_val/max_pos are final
//   sram_en     SRAM read enable
//   sram_addr   SRAM read address (holds while sram_en is low)
//   sram_rdata  signed SRAM read data, one cycle after the address
//   corr_valid  one pulse per lag
//   corr_lag    lag index of corr_val
//   corr_val    signed c[x]
//   max_val     running signed maximum of c[x]
//   max_pos     lag of max_val (the earliest lag wins on ties)
module xcorr_scheduler #(
    parameter int F_LEN  = 1024,
    parameter int G_LEN  = 64,
    parameter int NLAG   = 960,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int ACC_W  = 24,
    parameter int LAG_W  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              corr_valid,
    output logic [LAG_W-1:0]  corr_lag,
    output logic [ACC_W-1:0]  corr_val,
    output logic [ACC_W-1:0]  max_val,
    output logic [LAG_W-1:0]  max_pos
);

    localparam int CNT_W = $clog2(G_LEN + 1);
    localparam int GI_W  = (G_LEN > 1) ? $clog2(G_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_G,
        S_ACC,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LAG_W-1:0]         x_q, x_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  max_val_q, max_val_d;
    logic [LAG_W-1:0]         max_pos_q, max_pos_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;

    logic signed [DATA_W-1:0] g_q [G_LEN];
    logic                     g_we;
    logic [GI_W-1:0]          g_idx;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    // The read data always belongs to the address issued one cycle earlier.
    // That address was tap cnt-1, so both the cache write and the MAC
    // use the same index. In DRAIN, cnt is parked at G_LEN, so the last
    // tap still uses index G_LEN-1.
    assign g_idx    = GI_W'(cnt_q - 1'b1);
    assign prod     = $signed(sram_rdata) * g_q[g_idx];
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

    assign sram_addr  = addr_d;
    assign corr_lag   = x_q;
    assign corr_val   = acc_q;
    assign max_val    = max_val_q;
    assign max_pos    = max_pos_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        acc_d      = acc_q;
        max_val_d  = max_val_q;
        max_pos_d  = max_pos_q;
        addr_d     = addr_q;
        sram_en    = 1'b0;
        g_we       = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        corr_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD_G;
                    cnt_d     = '0;
                    x_d       = '0;
                    acc_d     = '0;
                    max_val_d = '0;
                    max_pos_d = '0;
                end
            end

            S_LOAD_G: begin
                if (cnt_q < CNT_W'(G_LEN)) begin
                    sram_en = 1'b1;
                    addr_d  = ADDR_W'(F_LEN) + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    g_we = 1'b1;
                end
                if (cnt_q == CNT_W'(G_LEN)) begin
                    state_d = S_ACC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_ACC: begin
                sram_en = 1'b1;
                addr_d  = ADDR_W'(x_q) + ADDR_W'(cnt_q);
                if (cnt_q == '0) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + prod_ext;
                end
                if (cnt_q == CNT_W'(G_LEN - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(G_LEN);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DRAIN: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_CMP;
            end

            S_CMP: begin
                corr_valid = 1'b1;
                // Lag 0 seeds the maximum. After that the compare is
                // strictly greater-than, so a tie keeps the earlier lag.
                if ((x_q == '0) || (acc_q > max_val_q)) begin
                    max_val_d = acc_q;
                    max_pos_d = x_q;
                end
                if (x_q < LAG_W'(NLAG - 1)) begin
                    x_d     = x_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            acc_q     <= '0;
            max_val_q <= '0;
            max_pos_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            acc_q     <= acc_d;
            max_val_q <= max_val_d;
            max_pos_q <= max_pos_d;
            addr_q    <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < G_LEN; i++) begin
                g_q[i] <= '0;
            end
        end else if (g_we) begin
            g_q[g_idx] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_xcorr_scheduler.sv
// Bench for xcorr_scheduler. It uses two instances: one small instance
// for the data-pattern table, and one instance at default parameters
// for full-size timing, mid-run reset and the tie pattern.
module tb_xcorr_scheduler;

    localparam int S_F = 40;
    localparam int S_G = 8;
    localparam int S_N = 32;
    localparam int D_F = 1024;
    localparam int D_G = 64;
    localparam int D_N = 960;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b1;
    logic start_s = 1'b0;
    logic start_f = 1'b0;

    logic        busy_s, done_s, en_s, cv_s;
    logic [10:0] addr_s;
    logic [7:0]  rdata_s = '0;
    logic [9:0]  lag_s, mp_s;
    logic [23:0] val_s, mv_s;

    logic        busy_f, done_f, en_f, cv_f;
    logic [10:0] addr_f;
    logic [7:0]  rdata_f = '0;
    logic [9:0]  lag_f, mp_f;
    logic [23:0] val_f, mv_f;

    xcorr_scheduler #(.F_LEN(S_F), .G_LEN(S_G), .NLAG(S_N)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start_s), .busy(busy_s), .done(done_s),
        .sram_en(en_s), .sram_addr(addr_s), .sram_rdata(rdata_s),
        .corr_valid(cv_s), .corr_lag(lag_s), .corr_val(val_s),
        .max_val(mv_s), .max_pos(mp_s)
    );

    xcorr_scheduler dut_f (
        .clk(clk), .reset_n(reset_n), .start(start_f), .busy(busy_f), .done(done_f),
        .sram_en(en_f), .sram_addr(addr_f), .sram_rdata(rdata_f),
        .corr_valid(cv_f), .corr_lag(lag_f), .corr_val(val_f),
        .max_val(mv_f), .max_pos(mp_f)
    );

    logic [7:0] mem [2][2048];

    always @(posedge clk) begin
        if (en_s) rdata_s <= mem[0][addr_s];
        if (en_f) rdata_f <= mem[1][addr_f];
    end

    int sel = 0;
    logic        o_busy, o_done, o_en, o_cv;
    logic [10:0] o_addr;
    logic [9:0]  o_lag, o_mp;
    logic [23:0] o_val, o_mv;
    assign o_busy = (sel != 0) ? busy_f : busy_s;
    assign o_done = (sel != 0) ? done_f : done_s;
    assign o_en   = (sel != 0) ? en_f   : en_s;
    assign o_cv   = (sel != 0) ? cv_f   : cv_s;
    assign o_addr = (sel != 0) ? addr_f : addr_s;
    assign o_lag  = (sel != 0) ? lag_f  : lag_s;
    assign o_mp   = (sel != 0) ? mp_f   : mp_s;
    assign o_val  = (sel != 0) ? val_f  : val_s;
    assign o_mv   = (sel != 0) ? mv_f   : mv_s;

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          lag;
        logic [23:0] val;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   pulses = 0;

    always @(negedge clk) begin
        if (o_cv) begin
            pulses++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got corr at lag %0d, required none", o_lag);
            end else begin
                cur = q.pop_front();
                $display("corr lag=%0d val=%0h (expect lag=%0d val=%0h)", o_lag, o_val, cur.lag, cur.val);
                chk("corr_lag", 32'(o_lag), 32'(cur.lag));
                chk("corr_val", 32'(o_val), 32'(cur.val));
            end
        end
    end

    typedef struct {
        int          f_mode;
        int          f_fill;
        int          spike_pos;
        int          spike_val;
        int          g_mode;
        int          g_fill;
        logic [23:0] exp_max;
        int          exp_pos;
        string       name;
    } vec_t;

    vec_t vt[4];
    vec_t vfull;

    task automatic load_case(int s, int flen, int glen, int nlag, vec_t v);
        int val;
        int acc;
        for (int a = 0; a < flen; a++) begin
            val = (v.f_mode != 0) ? (a - 20) : v.f_fill;
            if (a == v.spike_pos) val = v.spike_val;
            mem[s][a] = 8'(val);
        end
        for (int k = 0; k < glen; k++) begin
            val = (v.g_mode != 0) ? (4 - k) : v.g_fill;
            mem[s][flen + k] = 8'(val);
        end
        q.delete();
        for (int x = 0; x < nlag; x++) begin
            acc = 0;
            for (int k = 0; k < glen; k++) begin
                acc += int'($signed(mem[s][x + k])) * int'($signed(mem[s][flen + k]));
            end
            q.push_back('{x, 24'(acc)});
        end
    endtask

    task automatic set_start(int s, logic v);
        if (s != 0) start_f = v;
        else        start_s = v;
    endtask

    task automatic run(int s, int flen, int glen, int nlag, logic [23:0] exp_max, int exp_pos, string nm);
        int dl;
        int done_lbl;
        bit addr_bad;
        dl       = 1 + (glen + 1) + nlag * (glen + 2);
        done_lbl = -1;
        addr_bad = 1'b0;
        sel      = s;
        pulses   = 0;
        @(negedge clk);
        chk("idle_busy", 32'(o_busy), 0);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        chk("busy_after_start", 32'(o_busy), 1);
        for (int lbl = 1; lbl <= dl + 5; lbl++) begin
            if (lbl <= glen) begin
                if (!o_en || (o_addr != 11'(flen + lbl - 1))) addr_bad = 1'b1;
            end
            if (lbl == glen + 1) chk("load_drain_en", 32'(o_en), 0);
            if (lbl == glen + 2) chk("acc0_addr", {20'd0, o_en, o_addr}, {20'd0, 1'b1, 11'd0});
            if (lbl == 100) set_start(s, 1'b1);
            if (lbl == 101) set_start(s, 1'b0);
            if (o_done) begin
                done_lbl = lbl;
                break;
            end
            @(negedge clk);
        end
        set_start(s, 1'b0);
        chk("load_addr", 32'(addr_bad), 0);
        chk("done_time", 32'(done_lbl), 32'(dl));
        chk("max_val", 32'(o_mv), 32'(exp_max));
        chk("max_pos", 32'(o_mp), 32'(exp_pos));
        chk("pulse_count", 32'(pulses), 32'(nlag));
        @(negedge clk);
        chk("busy_after_done", 32'(o_busy), 0);
        chk("done_single", 32'(o_done), 0);
        chk("max_hold", 32'(o_mv), 32'(exp_max));
        chk("sb_empty", 32'(q.size()), 0);
        $display("run %s inst=%0d max_val=%0h max_pos=%0d done_at=%0d pulses=%0d", nm, s, o_mv, o_mp, done_lbl, pulses);
    endtask

    task automatic midrun_reset(int s, int lag, int bound, bit max_set);
        bit found;
        found = 1'b0;
        sel   = s;
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_cv && (o_lag == 10'(lag))) begin
                found = 1'b1;
                break;
            end
        end
        chk("midrun_reach", 32'(found), 1);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(o_busy), 1);
        chk("pre_rst_lag", 32'(o_lag), 32'(lag + 1));
        if (max_set) chk("pre_rst_max", 32'(o_mv), 32'h7F);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_en", 32'(o_en), 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_cv", 32'(o_cv), 0);
        chk("rst_lag", 32'(o_lag), 0);
        chk("rst_val", 32'(o_val), 0);
        chk("rst_max", {o_mv, 8'd0} | 32'(o_mp), 0);
        $display("midrun reset inst=%0d at lag %0d", s, lag + 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        q.delete();
    endtask

    initial begin
        vt[0] = '{0,    0, 20,  127, 0,    1, 24'h00007F, 13, "tie"};
        vt[1] = '{0,   -1, -1,    0, 0,    1, 24'hFFFFF8,  0, "all_neg"};
        vt[2] = '{0, -128, -1,    0, 0, -128, 24'h020000,  0, "extremes"};
        vt[3] = '{1,    0, -1,    0, 1,    0, 24'h000010, 31, "ramp"};
        vfull = '{0,    0, 500, 127, 0,    1, 24'h00007F, 437, "tie_full"};

        #1 reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("reset_busy", 32'(o_busy), 0);
            chk("reset_done", 32'(o_done), 0);
            chk("reset_en", 32'(o_en), 0);
            chk("reset_cv", 32'(o_cv), 0);
            chk("reset_max_val", 32'(o_mv), 0);
            chk("reset_max_pos", 32'(o_mp), 0);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            load_case(0, S_F, S_G, S_N, vt[i]);
            run(0, S_F, S_G, S_N, vt[i].exp_max, vt[i].exp_pos, vt[i].name);
        end

        load_case(0, S_F, S_G, S_N, vt[0]);
        midrun_reset(0, 19, 1000, 1'b1);
        load_case(0, S_F, S_G, S_N, vt[0]);
        run(0, S_F, S_G, S_N, vt[0].exp_max, vt[0].exp_pos, "tie_after_reset");

        load_case(1, D_F, D_G, D_N, vfull);
        midrun_reset(1, 99, 8000, 1'b0);
        load_case(1, D_F, D_G, D_N, vfull);
        run(1, D_F, D_G, D_N, vfull.exp_max, vfull.exp_pos, vfull.name);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
